wb_stage: RTL and testbench
===========================

# wb_stage

Writeback stage of the RISC-V core: the return path from execute/memory back to the register file, the counterpart of the operand-selection path that feeds the ALU. It accepts one retiring instruction at a time from execute via valid/ready. It selects the writeback source (ALU result, load data, or PC+4), waits for the data-memory response on loads, and sign/zero-extends sub-word loads. It then issues a single registered write pulse to the regfile.

## Interface
Parameters:
- none (widths come from `type_pkg`: `addr_t`, `data_t` are 32 bits)

Ports:
- `clk`  in  1  core clock; only clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ex_valid`  in  1  execute presents a retiring instruction
- `ex_ready`  out  1  stage can accept this cycle
- `ex_alu_result`  in  data_t  ALU result; also load address for loads
- `ex_pc`  in  addr_t  instruction PC
- `ex_rd`  in  5  destination register index
- `ex_sel`  in  sel_wb_t  SEL_WB_NONE / SEL_WB_ALU / SEL_WB_MEM / SEL_WB_PC4
- `ex_funct3`  in  3  load width/sign code
- `dmem_rvalid`  in  1  load data valid (one-cycle pulse)
- `dmem_rdata`  in  data_t  raw aligned 32-bit word
- `rd_we`  out  1  regfile write enable, one-cycle pulse
- `rd_addr`  out  5  regfile write index
- `rd_data`  out  data_t  regfile write data

## Operation
- FSM states: `WB_IDLE`, `WB_WAIT_LOAD`.
- `WB_IDLE`: `ex_ready=1`. A transfer occurs when `ex_valid && ex_ready`.
  - `ex_sel` ALU: `rd_data <= ex_alu_result`, `rd_we <= 1` on the accepting edge.
  - `ex_sel` PC4: `rd_data <= ex_pc + 4`, mod 2^32 (wraps at 0xFFFF_FFFC → 0).
  - `ex_sel` NONE: nothing written.
  - `ex_sel` MEM: capture rd, funct3, `ex_alu_result[1:0]`; go to `WB_WAIT_LOAD`.
- `WB_WAIT_LOAD`: `ex_ready=0`. On `dmem_rvalid`: `rd_data <=` extended data, `rd_we <= 1`, return to `WB_IDLE`.
- Load extension, using the captured offset:
  - 000 LB: byte[off], sign-extended
  - 100 LBU: byte[off], zero-extended
  - 001 LH: half[off[1]], sign-extended; off[0] ignored
  - 101 LHU: half[off[1]], zero-extended; off[0] ignored
  - 010 LW: full word
  - any other code: full word
- rd = 0: `rd_we` is never asserted. A load to x0 still waits for `dmem_rvalid`.
- `dmem_rvalid` in `WB_IDLE` is ignored.
- `rd_we` lasts exactly one cycle. It deasserts the next cycle unless a new write commits on that edge.
- Reset (`rst_n=0` at an edge): state to `WB_IDLE`; `rd_we=0`, `rd_addr=0`, `rd_data=0`. A pending load is dropped, and a `dmem_rvalid` arriving after reset is ignored.

## Timing
- Non-load instruction accepted at edge N: `rd_we` high during cycle N→N+1.
- Load: `dmem_rvalid` sampled at edge M gives `rd_we` high during M→M+1. `ex_ready` returns to 1 in that same cycle, so back-to-back loads and ALU ops lose no cycles beyond the memory wait.
- `ex_ready` is a pure function of state (no combinational path from `ex_valid`).
- Throughput for non-loads: 1 instruction per cycle.

## Configuration
- Macro `WB_FORWARD_EN`.
- Defined: adds these outputs for the operand muxes and hazard unit:
  - `fwd_valid`, `fwd_rd`, `fwd_data`: combinational copies of `rd_we`, `rd_addr`, `rd_data`.
  - `load_pending`: 1 in `WB_WAIT_LOAD`.
  - `pending_rd`: captured rd, 0 when idle.
- Undefined: these ports do not exist; the hazard unit must stall on all loads.

## Structure
- New package `wb_pkg`:
  - `sel_wb_t` enum
  - `wb_state_t` enum
  - funct3 load constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`
- `addr_t`, `data_t` from `type_pkg`.
- One sub-module, `load_extend`: purely combinational (rdata, funct3, offset → extended data), instantiated once.

## Test plan
- ALU write: ex_sel=ALU, rd=5, result=0xDEAD_BEEF → next cycle `rd_we=1`, `rd_addr=5`, `rd_data=0xDEADBEEF`; one cycle only.
- PC4 wrap: ex_pc=0xFFFF_FFFC, sel=PC4, rd=1 → `rd_data=0x0000_0000`.
- LB/LBU: rdata=0x80FF_7F01, offset 3 → LB 0xFFFF_FF80, LBU 0x0000_0080. LH at offset 2 → 0xFFFF_80FF.
- Load stall: load accepted, `dmem_rvalid` 3 cycles later → `ex_ready=0` for those cycles; `rd_we` one cycle after rvalid; a following ALU op is accepted in that same cycle and writes next cycle.
- x0 suppression: rd=0 with ALU and with load → `rd_we` never asserted; the FSM still waits for rvalid on the load.
- Reset mid-load: `rst_n=0` in `WB_WAIT_LOAD`, then rvalid after release → no `rd_we`; all outputs 0; `ex_ready=1`.

Source files
------------

// File: rtl/type_pkg.sv
// rtl/type_pkg.sv - core-wide address and data word types
package type_pkg;
    typedef logic [31:0] addr_t;
    typedef logic [31:0] data_t;
endpackage

// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - writeback stage enums and load funct3 codes
package wb_pkg;
    typedef enum logic [1:0] {
        SEL_WB_NONE = 2'd0,
        SEL_WB_ALU  = 2'd1,
        SEL_WB_MEM  = 2'd2,
        SEL_WB_PC4  = 2'd3
    } sel_wb_t;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_stage_load_extend.sv
// rtl/wb_stage_load_extend.sv - load_extend: lane select and sign/zero extension of sub-word loads
module load_extend
    import type_pkg::*;
    import wb_pkg::*;
(
    input  data_t       rdata,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    output data_t       data
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[7:0];
        case (offset)
            2'd0:    lane_b = rdata[7:0];
            2'd1:    lane_b = rdata[15:8];
            2'd2:    lane_b = rdata[23:16];
            default: lane_b = rdata[31:24];
        endcase
        // Halfword lane comes from offset[1] only; misaligned offset[0] is ignored.
        lane_h = offset[1] ? rdata[31:16] : rdata[15:0];

        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{lane_b[7]}}, lane_b};
            F3_LBU:  data = {24'd0, lane_b};
            F3_LH:   data = {{16{lane_h[15]}}, lane_h};
            F3_LHU:  data = {16'd0, lane_h};
            default: data = rdata;
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// rtl/wb_stage.sv - writeback stage: source select, load wait/extend, registered regfile write
// Optional forwarding/hazard outputs enabled by macro WB_FORWARD_EN.
module wb_stage
    import type_pkg::*;
    import wb_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    output logic        ex_ready,
    input  data_t       ex_alu_result,
    input  addr_t       ex_pc,
    input  logic [4:0]  ex_rd,
    input  sel_wb_t     ex_sel,
    input  logic [2:0]  ex_funct3,
    input  logic        dmem_rvalid,
    input  data_t       dmem_rdata,
`ifdef WB_FORWARD_EN
    output logic        fwd_valid,
    output logic [4:0]  fwd_rd,
    output data_t       fwd_data,
    output logic        load_pending,
    output logic [4:0]  pending_rd,
`endif
    output logic        rd_we,
    output logic [4:0]  rd_addr,
    output data_t       rd_data
);
    wb_state_t  state, state_next;
    logic [4:0] cap_rd;
    logic [2:0] cap_funct3;
    logic [1:0] cap_offset;
    data_t      load_data;

    load_extend u_load_extend (
        .rdata  (dmem_rdata),
        .funct3 (cap_funct3),
        .offset (cap_offset),
        .data   (load_data)
    );

    assign ex_ready = (state == WB_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= WB_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            WB_IDLE:      if (ex_valid && ex_sel == SEL_WB_MEM) state_next = WB_WAIT_LOAD;
            WB_WAIT_LOAD: if (dmem_rvalid) state_next = WB_IDLE;
            default:      state_next = WB_IDLE;
        endcase
    end

    // Writes to x0 are suppressed entirely so rd_addr/rd_data keep the last real write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_we      <= 1'b0;
            rd_addr    <= 5'd0;
            rd_data    <= '0;
            cap_rd     <= 5'd0;
            cap_funct3 <= 3'd0;
            cap_offset <= 2'd0;
        end else begin
            rd_we <= 1'b0;
            if (state == WB_IDLE && ex_valid) begin
                case (ex_sel)
                    SEL_WB_ALU: if (ex_rd != 5'd0) begin
                        rd_we   <= 1'b1;
                        rd_addr <= ex_rd;
                        rd_data <= ex_alu_result;
                    end
                    SEL_WB_PC4: if (ex_rd != 5'd0) begin
                        rd_we   <= 1'b1;
                        rd_addr <= ex_rd;
                        rd_data <= ex_pc + 32'd4;
                    end
                    SEL_WB_MEM: begin
                        cap_rd     <= ex_rd;
                        cap_funct3 <= ex_funct3;
                        cap_offset <= ex_alu_result[1:0];
                    end
                    default: ;
                endcase
            end else if (state == WB_WAIT_LOAD && dmem_rvalid && cap_rd != 5'd0) begin
                rd_we   <= 1'b1;
                rd_addr <= cap_rd;
                rd_data <= load_data;
            end
        end
    end

`ifdef WB_FORWARD_EN
    assign fwd_valid    = rd_we;
    assign fwd_rd       = rd_addr;
    assign fwd_data     = rd_data;
    assign load_pending = (state == WB_WAIT_LOAD);
    assign pending_rd   = (state == WB_WAIT_LOAD) ? cap_rd : 5'd0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb/tb_wb_stage.sv - scoreboard bench for wb_stage
module tb_wb_stage;
    import type_pkg::*;
    import wb_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ex_valid;
    logic       ex_ready;
    data_t      ex_alu_result;
    addr_t      ex_pc;
    logic [4:0] ex_rd;
    sel_wb_t    ex_sel;
    logic [2:0] ex_funct3;
    logic       dmem_rvalid;
    data_t      dmem_rdata;
    logic       rd_we;
    logic [4:0] rd_addr;
    data_t      rd_data;
`ifdef WB_FORWARD_EN
    logic       fwd_valid;
    logic [4:0] fwd_rd;
    data_t      fwd_data;
    logic       load_pending;
    logic [4:0] pending_rd;
`endif

    wr_t exp_q[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    wb_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ex_valid      (ex_valid),
        .ex_ready      (ex_ready),
        .ex_alu_result (ex_alu_result),
        .ex_pc         (ex_pc),
        .ex_rd         (ex_rd),
        .ex_sel        (ex_sel),
        .ex_funct3     (ex_funct3),
        .dmem_rvalid   (dmem_rvalid),
        .dmem_rdata    (dmem_rdata),
`ifdef WB_FORWARD_EN
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data),
        .load_pending  (load_pending),
        .pending_rd    (pending_rd),
`endif
        .rd_we         (rd_we),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data)
    );

    function automatic logic [31:0] model_ext(logic [31:0] w, logic [2:0] f3, logic [1:0] off);
        logic [31:0] sb;
        logic [31:0] sh;
        sb = w >> (32'(off) * 8);
        sh = off[1] ? (w >> 16) : w;
        case (f3)
            3'b000:  return {{24{sb[7]}}, sb[7:0]};
            3'b100:  return {24'd0, sb[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b101:  return {16'd0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    // Every write pulse seen on the regfile port must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rd_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_we: rd_we=1 addr=%0d data=%h, required no write", rd_addr, rd_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (rd_addr !== e.addr || rd_data !== e.data) begin
                    miscompares++;
                    $display("FAIL write: got addr=%0d data=%h, required addr=%0d data=%h",
                             rd_addr, rd_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic check_ready(input logic exp, input string name);
        vectors++;
        if (ex_ready !== exp) begin
            miscompares++;
            $display("FAIL %s: ex_ready=%b required %b", name, ex_ready, exp);
        end
    endtask

    task automatic send(input sel_wb_t sel, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3);
        wr_t e;
        ex_valid = 1'b1;
        ex_sel = sel;
        ex_rd = rd;
        ex_alu_result = alu;
        ex_pc = pc;
        ex_funct3 = f3;
        if (rd != 5'd0 && (sel == SEL_WB_ALU || sel == SEL_WB_PC4)) begin
            e.addr = rd;
            e.data = (sel == SEL_WB_ALU) ? alu : pc + 32'd4;
            exp_q.push_back(e);
        end
        @(negedge clk);
        ex_valid = 1'b0;
    endtask

    task automatic do_load(input logic [4:0] rd, input logic [31:0] addr, input logic [2:0] f3,
                           input int wait_cycles, input logic [31:0] word);
        wr_t e;
        send(SEL_WB_MEM, rd, addr, 32'h0, f3);
        for (int i = 0; i < wait_cycles; i++) begin
            check_ready(1'b0, "load_stall");
            @(negedge clk);
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = word;
        if (rd != 5'd0) begin
            e.addr = rd;
            e.data = model_ext(word, f3, addr[1:0]);
            exp_q.push_back(e);
        end
        @(negedge clk);
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: we=%b addr=%0d data=%h required 0/0/0", rd_we, rd_addr, rd_data);
        end
        check_ready(1'b1, "reset_ready");
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_alu_pc4();
        send(SEL_WB_ALU, 5'd5, 32'hDEAD_BEEF, 32'h0, 3'd0);
        send(SEL_WB_PC4, 5'd1, 32'h0, 32'hFFFF_FFFC, 3'd0);
        send(SEL_WB_PC4, 5'd31, 32'h0, 32'h0000_1000, 3'd0);
        send(SEL_WB_NONE, 5'd9, 32'h1234_5678, 32'h0, 3'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 6; i++)
            send(SEL_WB_ALU, 5'(i + 10), $urandom, 32'h0, 3'd0);
        @(negedge clk);
    endtask

    task automatic test_load_extend();
        do_load(5'd3, 32'h0000_0103, F3_LB,  0, 32'h80FF_7F01);
        do_load(5'd4, 32'h0000_0103, F3_LBU, 1, 32'h80FF_7F01);
        do_load(5'd6, 32'h0000_0102, F3_LH,  0, 32'h80FF_7F01);
        do_load(5'd7, 32'h0000_0103, F3_LHU, 0, 32'h80FF_7F01);
        do_load(5'd8, 32'h0000_0100, F3_LH,  0, 32'h80FF_7F01);
        do_load(5'd9, 32'h0000_0101, F3_LB,  0, 32'h80FF_7F01);
        do_load(5'd10, 32'h0000_0100, F3_LW, 0, 32'hCAFE_F00D);
        do_load(5'd11, 32'h0000_0102, 3'b111, 0, 32'h1357_9BDF);
    endtask

    task automatic test_load_stall();
        do_load(5'd12, 32'h0000_0200, F3_LW, 3, 32'hA5A5_0001);
        check_ready(1'b1, "ready_after_rvalid");
        send(SEL_WB_ALU, 5'd13, 32'h0BAD_CAFE, 32'h0, 3'd0);
        @(negedge clk);
    endtask

    task automatic test_x0();
        send(SEL_WB_ALU, 5'd0, 32'hFFFF_FFFF, 32'h0, 3'd0);
        send(SEL_WB_PC4, 5'd0, 32'h0, 32'h40, 3'd0);
        do_load(5'd0, 32'h0, F3_LW, 2, 32'h7777_7777);
        check_ready(1'b1, "x0_load_done");
        // rvalid while idle must not produce a write
        dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check_ready(1'b1, "idle_rvalid");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_load();
        send(SEL_WB_ALU, 5'd20, 32'h1111_2222, 32'h0, 3'd0);
        send(SEL_WB_MEM, 5'd21, 32'h0, 32'h0, F3_LW);
        check_ready(1'b0, "mid_load_wait");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (rd_we !== 1'b0 || rd_addr !== 5'd0 || rd_data !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_load_reset: we=%b addr=%0d data=%h required 0/0/0", rd_we, rd_addr, rd_data);
        end
        check_ready(1'b1, "mid_load_ready");
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hDEAD_0000;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        repeat (2) @(negedge clk);
        check_ready(1'b1, "post_reset_ready");
    endtask

    initial begin
        rst_n = 1'b0;
        ex_valid = 1'b0;
        ex_alu_result = '0;
        ex_pc = '0;
        ex_rd = '0;
        ex_sel = SEL_WB_NONE;
        ex_funct3 = '0;
        dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        @(negedge clk);
        test_reset();
        test_alu_pc4();
        test_back_to_back();
        test_load_extend();
        test_load_stall();
        test_x0();
        test_reset_mid_load();
        repeat (3) @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_writes: %0d expected writes never seen, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
